// File: rtl/cpu_controller_if.sv
// Control bundle between cpu_controller (master) and the datapath/memory side (slave).
interface cpu_controller_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic       write;
  logic       load_ir;
  logic       load_pc;
  logic       reset_pc;
  logic       load_addr;
  logic       addr_sel;
  logic [1:0] mem_cmd;
  logic       halted;

  modport master (
    input  opcode, op,
    output nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write,
           load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd, halted
  );

  modport slave (
    output opcode, op,
    input  nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write,
           load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd, halted
  );
endinterface

// File: rtl/cpu_controller.sv
// Moore control FSM for the simple CPU: fetch, decode, ALU, LDR/STR and optional HALT.
// Define CPU_CONTROLLER_HALT_EN to make opcode 111 halt; otherwise it is a NOP.
module cpu_controller (
  input  logic          clk,
  input  logic          reset,
  cpu_controller_if.master bus
);

  typedef enum logic [4:0] {
    S_RST,
    S_IF1,
    S_IF2,
    S_UPC,
    S_DEC,
    S_WIMM,
    S_GETA,
    S_GETB,
    S_EXEC,
    S_EXECZ,
    S_WREG,
    S_CMPS,
    S_ADDRL,
    S_LADRL,
    S_MRD,
    S_MWB,
    S_ADDRS,
    S_LADRS,
    S_GETD,
    S_PASS,
    S_MST
`ifdef CPU_CONTROLLER_HALT_EN
    , S_HALT
`endif
  } state_e;

  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
`ifdef CPU_CONTROLLER_HALT_EN
    logic       halted;
`endif
  } ctl_t;

  state_e state_q, state_d;
  ctl_t   ctl_q;

  // Opcode is only consulted in DEC/GETA/GETB, so the LDR/STR and MOV/MVN
  // distinctions are carried forward as separate states.
  function automatic ctl_t decode(input state_e s);
    ctl_t c;
    c = '0;
    case (s)
      S_RST:   begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
      S_IF1:   begin c.addr_sel = 1'b1; c.mem_cmd = 2'b01; end
      S_IF2:   begin c.addr_sel = 1'b1; c.mem_cmd = 2'b01; c.load_ir = 1'b1; end
      S_UPC:   c.load_pc = 1'b1;
      S_WIMM:  begin c.nsel = 3'b001; c.vsel = 2'b10; c.write = 1'b1; end
      S_GETA:  begin c.nsel = 3'b001; c.loada = 1'b1; end
      S_GETB:  begin c.nsel = 3'b100; c.loadb = 1'b1; end
      S_EXEC:  c.loadc = 1'b1;
      S_EXECZ: begin c.loadc = 1'b1; c.asel = 1'b1; end
      S_WREG:  begin c.nsel = 3'b010; c.vsel = 2'b00; c.write = 1'b1; end
      S_CMPS:  c.loads = 1'b1;
      S_ADDRL,
      S_ADDRS: begin c.bsel = 1'b1; c.loadc = 1'b1; end
      S_LADRL,
      S_LADRS: c.load_addr = 1'b1;
      S_MRD:   c.mem_cmd = 2'b01;
      S_MWB:   begin
        c.mem_cmd = 2'b01; c.nsel = 3'b010; c.vsel = 2'b11; c.write = 1'b1;
      end
      S_GETD:  begin c.nsel = 3'b010; c.loadb = 1'b1; end
      S_PASS:  begin c.asel = 1'b1; c.loadc = 1'b1; end
      S_MST:   c.mem_cmd = 2'b10;
`ifdef CPU_CONTROLLER_HALT_EN
      S_HALT:  c.halted = 1'b1;
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   state_d = S_IF1;
      S_IF1:   state_d = S_IF2;
      S_IF2:   state_d = S_UPC;
      S_UPC:   state_d = S_DEC;
      S_DEC: begin
        casez ({bus.opcode, bus.op})
          5'b110_10: state_d = S_WIMM;
          5'b110_00: state_d = S_GETB;
          5'b101_00,
          5'b101_01,
          5'b101_10: state_d = S_GETA;
          5'b101_11: state_d = S_GETB;
          5'b011_??,
          5'b100_??: state_d = S_GETA;
`ifdef CPU_CONTROLLER_HALT_EN
          5'b111_??: state_d = S_HALT;
`endif
          default:   state_d = S_IF1;
        endcase
      end
      S_GETA: begin
        case (bus.opcode)
          3'b101:  state_d = S_GETB;
          3'b011:  state_d = S_ADDRL;
          3'b100:  state_d = S_ADDRS;
          default: state_d = S_IF1;
        endcase
      end
      S_GETB: begin
        case ({bus.opcode, bus.op})
          5'b101_01: state_d = S_CMPS;
          5'b101_11,
          5'b110_00: state_d = S_EXECZ;
          default:   state_d = S_EXEC;
        endcase
      end
      S_EXEC,
      S_EXECZ: state_d = S_WREG;
      S_ADDRL: state_d = S_LADRL;
      S_LADRL: state_d = S_MRD;
      S_MRD:   state_d = S_MWB;
      S_ADDRS: state_d = S_LADRS;
      S_LADRS: state_d = S_GETD;
      S_GETD:  state_d = S_PASS;
      S_PASS:  state_d = S_MST;
`ifdef CPU_CONTROLLER_HALT_EN
      S_HALT:  state_d = S_HALT;
`endif
      default: state_d = S_IF1;
    endcase
  end

  // Outputs are registered from the next state, so they stay a pure function of state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      ctl_q   <= decode(S_RST);
    end else begin
      state_q <= state_d;
      ctl_q   <= decode(state_d);
    end
  end

  assign bus.nsel      = ctl_q.nsel;
  assign bus.vsel      = ctl_q.vsel;
  assign bus.loada     = ctl_q.loada;
  assign bus.loadb     = ctl_q.loadb;
  assign bus.loadc     = ctl_q.loadc;
  assign bus.loads     = ctl_q.loads;
  assign bus.asel      = ctl_q.asel;
  assign bus.bsel      = ctl_q.bsel;
  assign bus.write     = ctl_q.write;
  assign bus.load_ir   = ctl_q.load_ir;
  assign bus.load_pc   = ctl_q.load_pc;
  assign bus.reset_pc  = ctl_q.reset_pc;
  assign bus.load_addr = ctl_q.load_addr;
  assign bus.addr_sel  = ctl_q.addr_sel;
  assign bus.mem_cmd   = ctl_q.mem_cmd;
`ifdef CPU_CONTROLLER_HALT_EN
  assign bus.halted    = ctl_q.halted;
`else
  assign bus.halted    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: per-instruction step lists expected cycle by cycle.
module tb_cpu_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_controller_if bus();

  cpu_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       halted;
  } vec_t;

  typedef struct {
    vec_t  v;
    string tag;
  } exp_t;

  exp_t  sb[$];
  string plan[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  logic  mon_en   = 1'b0;
  vec_t  got;

  assign got = {bus.nsel, bus.vsel, bus.loada, bus.loadb, bus.loadc, bus.loads,
                bus.asel, bus.bsel, bus.write, bus.load_ir, bus.load_pc,
                bus.reset_pc, bus.load_addr, bus.addr_sel, bus.mem_cmd, bus.halted};

  // Output table for each named microstep of the instruction set.
  function automatic vec_t step(input string s);
    vec_t v;
    v = '0;
    case (s)
      "RST":      begin v.reset_pc = 1; v.load_pc = 1; end
      "IF1":      begin v.addr_sel = 1; v.mem_cmd = 2'b01; end
      "IF2":      begin v.addr_sel = 1; v.mem_cmd = 2'b01; v.load_ir = 1; end
      "UPC":      v.load_pc = 1;
      "DEC":      v = '0;
      "WIMM":     begin v.nsel = 3'b001; v.vsel = 2'b10; v.write = 1; end
      "GETA":     begin v.nsel = 3'b001; v.loada = 1; end
      "GETB":     begin v.nsel = 3'b100; v.loadb = 1; end
      "EXEC":     v.loadc = 1;
      "EXEC_MOV": begin v.loadc = 1; v.asel = 1; end
      "WREG":     begin v.nsel = 3'b010; v.write = 1; end
      "CMPS":     v.loads = 1;
      "ADDR":     begin v.bsel = 1; v.loadc = 1; end
      "LADR":     v.load_addr = 1;
      "MRD":      v.mem_cmd = 2'b01;
      "MWB":      begin v.mem_cmd = 2'b01; v.nsel = 3'b010; v.vsel = 2'b11; v.write = 1; end
      "GETD":     begin v.nsel = 3'b010; v.loadb = 1; end
      "PASS":     begin v.asel = 1; v.loadc = 1; end
      "MST":      v.mem_cmd = 2'b10;
      "HALT":     v.halted = 1;
      default:    v = '0;
    endcase
    return v;
  endfunction

  // Reference model: classify the instruction, then list its steps after the common fetch.
  function automatic void plan_instr(input logic [2:0] opc, input logic [1:0] op,
                                     input int halt_len);
    string cls;
    cls = "NOP";
    if (opc == 3'b110 && op == 2'b10) cls = "MOVI";
    else if (opc == 3'b110 && op == 2'b00) cls = "MOVR";
    else if (opc == 3'b101) begin
      case (op)
        2'b00:   cls = "ADD";
        2'b01:   cls = "CMP";
        2'b10:   cls = "AND";
        default: cls = "MVN";
      endcase
    end
    else if (opc == 3'b011) cls = "LDR";
    else if (opc == 3'b100) cls = "STR";
`ifdef CPU_CONTROLLER_HALT_EN
    else if (opc == 3'b111) cls = "HLT";
`endif
    plan = {"IF1", "IF2", "UPC", "DEC"};
    case (cls)
      "MOVI":       plan.push_back("WIMM");
      "MOVR", "MVN": plan = {plan, "GETB", "EXEC_MOV", "WREG"};
      "ADD", "AND": plan = {plan, "GETA", "GETB", "EXEC", "WREG"};
      "CMP":        plan = {plan, "GETA", "GETB", "CMPS"};
      "LDR":        plan = {plan, "GETA", "ADDR", "LADR", "MRD", "MWB"};
      "STR":        plan = {plan, "GETA", "ADDR", "LADR", "GETD", "PASS", "MST"};
      "HLT":        for (int i = 0; i < halt_len; i++) plan.push_back("HALT");
      default:      ;
    endcase
  endfunction

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
      sb.push_back('{step("RST"), "RST"});
      mon_en = 1'b1;
    end
    reset = 1'b0;
  endtask

  // Garbage opcode during IF1/IF2 exercises the sample-only-after-fetch rule.
  task automatic run_instr(input logic [2:0] opc, input logic [1:0] op,
                           input int abort_at, input int halt_len);
    int   n;
    int   last;
    logic ab;
    plan_instr(opc, op, halt_len);
    n    = plan.size();
    ab   = (abort_at >= 0) && (abort_at < n);
    last = ab ? abort_at : n - 1;
    for (int i = 0; i <= last; i++) sb.push_back('{step(plan[i]), plan[i]});
    for (int i = 0; i <= last; i++) begin
      @(posedge clk); #1;
      if (i < 2) begin
        bus.opcode = 3'($urandom_range(0, 7));
        bus.op     = 2'($urandom_range(0, 3));
      end else if (i == 2) begin
        bus.opcode = opc;
        bus.op     = op;
      end
      if (ab && i == last) reset = 1'b1;
    end
    if (ab) do_reset(1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL scoreboard_underflow: got %h required an expected entry", got);
      end else begin
        e = sb.pop_front();
        if (got === e.v) n_pass++;
        else $display("FAIL step_%s: got %h required %h", e.tag, got, e.v);
      end
      n_checks++;
      if (got.mem_cmd !== 2'b11 && !(got.write === 1'b1 && got.mem_cmd === 2'b10)) n_pass++;
      else $display("FAIL bus_invariant: got mem_cmd=%b write=%b required no 11 and no write with 10",
                    got.mem_cmd, got.write);
    end
  end

  initial begin
    logic [2:0] ropc;
    logic [1:0] rop;
    int         rab;
    reset      = 1'b1;
    bus.opcode = '0;
    bus.op     = '0;
    do_reset(2);

    run_instr(3'b110, 2'b10, -1, 0);  // MOV imm
    run_instr(3'b101, 2'b00, -1, 0);  // ADD
    run_instr(3'b100, 2'b00, -1, 0);  // STR
    run_instr(3'b011, 2'b00, 7, 0);   // LDR aborted in MRD
    run_instr(3'b110, 2'b00, -1, 0);  // MOV reg
    run_instr(3'b101, 2'b11, -1, 0);  // MVN
    run_instr(3'b101, 2'b10, -1, 0);  // AND
    run_instr(3'b101, 2'b01, -1, 0);  // CMP
    run_instr(3'b011, 2'b01, -1, 0);  // LDR
    run_instr(3'b000, 2'b00, -1, 0);  // NOP
    run_instr(3'b110, 2'b01, -1, 0);  // NOP variant
    run_instr(3'b100, 2'b11, 8, 0);   // STR aborted in PASS

    for (int k = 0; k < 40; k++) begin
      ropc = 3'($urandom_range(0, 7));
      rop  = 2'($urandom_range(0, 3));
`ifdef CPU_CONTROLLER_HALT_EN
      if (ropc == 3'b111) ropc = 3'b000;
`endif
      rab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1;
      run_instr(ropc, rop, rab, 0);
    end

`ifdef CPU_CONTROLLER_HALT_EN
    run_instr(3'b111, 2'b10, 4 + 50 - 1, 50);
`else
    run_instr(3'b111, 2'b10, -1, 0);
`endif
    run_instr(3'b110, 2'b10, -1, 0);

    @(negedge clk); #1;
    mon_en = 1'b0;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
